// File: rtl/router_src_parser.sv
// Source-side packet parser for a 1xN router: decodes the header destination,
// steers bytes to one of N_DEST FIFO write ports and checks parity.
// Optional payload-length check is enabled by defining ROUTER_LEN_CHECK_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a header byte (pkt_valid=1)
// S_LOAD  | valid destination: payload and parity bytes written to target
// S_DROP  | invalid destination: bytes consumed, never written
// S_CHECK | one cycle: compute error, pulse pkt_done, return to S_IDLE
module router_src_parser #(
  parameter int DATA_W = 8,
  parameter int N_DEST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              pkt_valid,
  input  logic [N_DEST-1:0] fifo_full,
  output logic              busy,
  output logic              error,
  output logic [DATA_W-1:0] data_out,
  output logic [N_DEST-1:0] wr_en,
  output logic              pkt_done
);

  localparam int ADDR_W = $clog2(N_DEST);
  localparam int LEN_W  = DATA_W - ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DROP, S_CHECK} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  parity_q, parity_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               drop_q, drop_d;
  logic               error_q, error_d;
  logic               pkt_done_q, pkt_done_d;
`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
`endif

  logic [ADDR_W-1:0]  hdr_dest;
  logic               hdr_ok, hdr_full, tgt_full;
  logic               accept;
  logic               len_bad;

  assign hdr_dest = din[ADDR_W-1:0];
  assign data_out = din;
  assign error    = error_q;
  assign pkt_done = pkt_done_q;

  // Compare against every legal index so out-of-range destinations never index fifo_full.
  always_comb begin
    hdr_ok   = 1'b0;
    hdr_full = 1'b0;
    tgt_full = 1'b0;
    for (int i = 0; i < N_DEST; i++) begin
      if (hdr_dest == ADDR_W'(i)) begin
        hdr_ok   = 1'b1;
        hdr_full = fifo_full[i];
      end
      if (target_q == ADDR_W'(i)) tgt_full = fifo_full[i];
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  assign len_bad = (count_q != len_q);
`else
  assign len_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q   <= '0;
      target_q   <= '0;
      drop_q     <= 1'b0;
      error_q    <= 1'b0;
      pkt_done_q <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
      count_q    <= '0;
      len_q      <= '0;
`endif
    end else begin
      parity_q   <= parity_d;
      target_q   <= target_d;
      drop_q     <= drop_d;
      error_q    <= error_d;
      pkt_done_q <= pkt_done_d;
`ifdef ROUTER_LEN_CHECK_EN
      count_q    <= count_d;
      len_q      <= len_d;
`endif
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    parity_d   = parity_q;
    target_d   = target_q;
    drop_d     = drop_q;
    error_d    = error_q;
    pkt_done_d = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
    count_d    = count_q;
    len_d      = len_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          target_d = hdr_dest;
          drop_d   = !hdr_ok;
          parity_d = din;
          error_d  = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
          count_d  = '0;
          len_d    = din[DATA_W-1:ADDR_W];
`endif
          state_d  = hdr_ok ? S_LOAD : S_DROP;
        end
      end
      S_LOAD, S_DROP: begin
        if (accept) begin
          parity_d = parity_q ^ din;
          if (pkt_valid) begin
`ifdef ROUTER_LEN_CHECK_EN
            if (count_q != '1) count_d = count_q + LEN_W'(1);
`endif
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        error_d    = (parity_q != '0) || drop_q || len_bad;
        pkt_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and write strobes (zero latency from din)
  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    wr_en  = '0;
    case (state_q)
      S_IDLE: begin
        busy   = pkt_valid && hdr_ok && hdr_full;
        accept = pkt_valid && !busy;
        if (accept && hdr_ok) wr_en[hdr_dest] = 1'b1;
      end
      S_LOAD: begin
        busy   = tgt_full;
        accept = !busy;
        if (accept) wr_en[target_q] = 1'b1;
      end
      S_DROP:  accept = 1'b1;
      S_CHECK: busy   = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_router_src_parser.sv
// Directed self-checking bench for router_src_parser (N_DEST=3, DATA_W=8).
module tb_router_src_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       pkt_valid;
  logic [2:0] fifo_full;
  logic       busy, error, pkt_done;
  logic [7:0] data_out;
  logic [2:0] wr_en;

  int checks = 0;
  int fails  = 0;

  router_src_parser #(.DATA_W(8), .N_DEST(3)) dut (
    .clk(clk), .rst(rst), .din(din), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .busy(busy), .error(error), .data_out(data_out), .wr_en(wr_en), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [7:0] d, input logic pv, input logic [2:0] ff);
    @(negedge clk);
    din = d; pkt_valid = pv; fifo_full = ff;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; pkt_valid = 1'b0; fifo_full = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, error, pkt_done, wr_en} !== 6'b0) begin
      fails++; $display("FAIL reset_state: got %b expected 000000", {busy, error, pkt_done, wr_en});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  // Header 0x0D: dest 1, len 3; payload 11 22 33; last byte is the parity byte.
  task automatic test_packet(input logic [7:0] par, input logic exp_err);
    logic [7:0] b [5];
    b = '{8'h0D, 8'h11, 8'h22, 8'h33, par};
    for (int i = 0; i < 5; i++) begin
      drive(b[i], (i < 4), 3'b000);
      checks++;
      if ({busy, wr_en, data_out} !== {1'b0, 3'b010, b[i]}) begin
        fails++; $display("FAIL pkt_byte%0d: got busy/wr/data %b/%b/%h expected 0/010/%h", i, busy, wr_en, data_out, b[i]);
      end
    end
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({busy, wr_en, pkt_done} !== 5'b1_000_0) begin
      fails++; $display("FAIL pkt_check_cycle: got busy/wr/done %b/%b/%b expected 1/000/0", busy, wr_en, pkt_done);
    end
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== {1'b1, exp_err}) begin
      fails++; $display("FAIL pkt_done_error: got done/err %b/%b expected 1/%b", pkt_done, error, exp_err);
    end
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== {1'b0, exp_err}) begin
      fails++; $display("FAIL pkt_done_one_cycle: got done/err %b/%b expected 0/%b", pkt_done, error, exp_err);
    end
  endtask

  task automatic test_error_clear();
    drive(8'h0D, 1'b1, 3'b000);
    checks++;
    if ({error, wr_en} !== 4'b1_010) begin
      fails++; $display("FAIL err_hold_before_hdr: got err/wr %b/%b expected 1/010", error, wr_en);
    end
    drive(8'h11, 1'b1, 3'b000);
    checks++;
    if (error !== 1'b0) begin
      fails++; $display("FAIL err_clear_on_hdr: got %b expected 0", error);
    end
    drive(8'h22, 1'b1, 3'b000);
    drive(8'h33, 1'b1, 3'b000);
    drive(8'h0D, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== 2'b10) begin
      fails++; $display("FAIL err_clear_pkt_end: got done/err %b/%b expected 1/0", pkt_done, error);
    end
  endtask

  task automatic test_fifo_full();
    drive(8'h0D, 1'b1, 3'b000);
    drive(8'h11, 1'b1, 3'b101);
    checks++;
    if ({busy, wr_en} !== 4'b0_010) begin
      fails++; $display("FAIL full_non_target: got busy/wr %b/%b expected 0/010", busy, wr_en);
    end
    for (int i = 0; i < 3; i++) begin
      drive(8'h22, 1'b1, 3'b010);
      checks++;
      if ({busy, wr_en} !== 4'b1_000) begin
        fails++; $display("FAIL full_stall%0d: got busy/wr %b/%b expected 1/000", i, busy, wr_en);
      end
    end
    drive(8'h22, 1'b1, 3'b000);
    checks++;
    if ({busy, wr_en, data_out} !== {1'b0, 3'b010, 8'h22}) begin
      fails++; $display("FAIL full_release: got busy/wr/data %b/%b/%h expected 0/010/22", busy, wr_en, data_out);
    end
    drive(8'h33, 1'b1, 3'b000);
    drive(8'h0D, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== 2'b10) begin
      fails++; $display("FAIL full_pkt_end: got done/err %b/%b expected 1/0", pkt_done, error);
    end
  endtask

  // Header 0x07: dest 3 (invalid), len 1; payload AA; parity AD gives zero XOR.
  task automatic test_invalid_dest();
    logic [7:0] b [3];
    b = '{8'h07, 8'hAA, 8'hAD};
    for (int i = 0; i < 3; i++) begin
      drive(b[i], (i < 2), 3'b111);
      checks++;
      if ({busy, wr_en} !== 4'b0_000) begin
        fails++; $display("FAIL drop_byte%0d: got busy/wr %b/%b expected 0/000", i, busy, wr_en);
      end
    end
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== 2'b11) begin
      fails++; $display("FAIL drop_pkt_end: got done/err %b/%b expected 1/1", pkt_done, error);
    end
  endtask

  task automatic test_mid_reset();
    drive(8'h0D, 1'b1, 3'b000);
    drive(8'h11, 1'b1, 3'b000);
    drive(8'h22, 1'b1, 3'b000);
    @(negedge clk); rst = 1'b1; din = 8'h00; pkt_valid = 1'b0;
    @(negedge clk); rst = 1'b0; din = 8'h33;
    #1;
    checks++;
    if ({wr_en, error, pkt_done} !== 5'b000_0_0) begin
      fails++; $display("FAIL mid_reset_idle: got wr/err/done %b/%b/%b expected 000/0/0", wr_en, error, pkt_done);
    end
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({error, pkt_done} !== 2'b00) begin
      fails++; $display("FAIL mid_reset_no_done: got err/done %b/%b expected 0/0", error, pkt_done);
    end
  endtask

  // 0x04: dest 0 len 1, parity 04^55=51.  0x06: dest 2 len 1, parity 06^66=60.
  task automatic test_back_to_back();
    drive(8'h04, 1'b1, 3'b000);
    drive(8'h55, 1'b1, 3'b000);
    drive(8'h51, 1'b0, 3'b000);
    checks++;
    if (wr_en !== 3'b001) begin
      fails++; $display("FAIL b2b_first_parity: got %b expected 001", wr_en);
    end
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h06, 1'b1, 3'b000);
    checks++;
    if ({pkt_done, error, busy, wr_en} !== 6'b1_0_0_100) begin
      fails++; $display("FAIL b2b_second_hdr: got done/err/busy/wr %b/%b/%b/%b expected 1/0/0/100", pkt_done, error, busy, wr_en);
    end
    drive(8'h66, 1'b1, 3'b000);
    drive(8'h60, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== 2'b10) begin
      fails++; $display("FAIL b2b_second_end: got done/err %b/%b expected 1/0", pkt_done, error);
    end
  endtask

  // 0x0D claims 3 payload bytes but only 2 follow; parity 0D^11^22=3E.
  task automatic test_len_check();
    logic exp_err;
`ifdef ROUTER_LEN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive(8'h0D, 1'b1, 3'b000);
    drive(8'h11, 1'b1, 3'b000);
    drive(8'h22, 1'b1, 3'b000);
    drive(8'h3E, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== {1'b1, exp_err}) begin
      fails++; $display("FAIL len_short: got done/err %b/%b expected 1/%b", pkt_done, error, exp_err);
    end
    // len=0: header 0x01 directly followed by parity 0x01.
    drive(8'h01, 1'b1, 3'b000);
    drive(8'h01, 1'b0, 3'b000);
    checks++;
    if (wr_en !== 3'b010) begin
      fails++; $display("FAIL len_zero_parity_wr: got %b expected 010", wr_en);
    end
    drive(8'h00, 1'b0, 3'b000);
    drive(8'h00, 1'b0, 3'b000);
    checks++;
    if ({pkt_done, error} !== 2'b10) begin
      fails++; $display("FAIL len_zero_end: got done/err %b/%b expected 1/0", pkt_done, error);
    end
  endtask

  task automatic test_hdr_busy();
    drive(8'h0D, 1'b1, 3'b010);
    checks++;
    if ({busy, wr_en} !== 4'b1_000) begin
      fails++; $display("FAIL hdr_target_full: got busy/wr %b/%b expected 1/000", busy, wr_en);
    end
    drive(8'h00, 1'b0, 3'b000);
  endtask

  initial begin
    test_reset();
    test_packet(8'h0D, 1'b0);
    test_packet(8'h0E, 1'b1);
    test_error_clear();
    test_fifo_full();
    test_invalid_dest();
    test_mid_reset();
    test_packet(8'h0D, 1'b0);
    test_back_to_back();
    test_len_check();
    test_hdr_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/router_src_parser.md
Name: router_src_parser

Overview:
- Source-side packet parser for a generalised 1xN router; replaces the fixed 1x3 input stage.
- Accepts a byte stream from the source agent under a pkt_valid/busy handshake and decodes the header destination.
- Steers header, payload and parity bytes into one of N_DEST destination FIFO write ports.
- Checks running parity; flags bad packets and invalid destinations on error.

Parameters:
- DATA_W, 8, byte width of din/data_out; must be > ADDR_W.
- N_DEST, 3, number of destination FIFOs; must be >= 2.
- ADDR_W (localparam), $clog2(N_DEST), width of header destination field din[ADDR_W-1:0].

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- din  input  DATA_W  byte from source.
- pkt_valid  input  1  high during header and payload bytes; low on the parity byte.
- fifo_full  input  N_DEST  per-destination FIFO full flags.
- busy  output  1  combinational; source must hold din/pkt_valid stable while high.
- error  output  DATA_W? no: 1  registered packet error flag.
- data_out  output  DATA_W  combinational copy of din.
- wr_en  output  N_DEST  combinational one-hot FIFO write strobes.
- pkt_done  output  1  registered one-cycle pulse at packet completion.

Behaviour:
- Reset: one clock, synchronous, active-high, named rst. On rst: state=IDLE, error=0, pkt_done=0, parity/count/target cleared. Mid-packet reset abandons the packet; no completion pulse.
- Accept rule: a byte is accepted on a posedge when busy=0 and the state permits it. wr_en[i]=accept && valid target==i. data_out=din. Zero latency.
- Header: din[ADDR_W-1:0]=dest; din[DATA_W-1:ADDR_W]=len (payload byte count).
- Parity: XOR of header, all payload bytes and the parity byte; must equal 0.
- IDLE:
  - pkt_valid=1: header is the candidate; busy = (dest<N_DEST) && fifo_full[dest].
  - On accept: latch dest; parity=din; count=0; error cleared to 0.
  - Go to LOAD if dest<N_DEST, else DROP.
- LOAD:
  - busy=fifo_full[target].
  - Accepted byte with pkt_valid=1: payload; written; parity^=din; count+1, saturating.
  - Accepted byte with pkt_valid=0: parity byte; written to the same FIFO; go to CHECK.
- DROP:
  - busy=0; bytes accepted, never written (wr_en=0); parity still accumulated.
  - Accepted byte with pkt_valid=0: go to CHECK.
- CHECK (1 cycle):
  - busy=1; no accept.
  - On exit edge: error=(parity!=0) || dropped || len mismatch (if enabled); pkt_done=1 for one cycle; go to IDLE.
- error holds its value until the next header is accepted or rst.
- fifo_full on a non-target FIFO has no effect.
- Simultaneous fifo_full rise and byte offer: the byte is not accepted and is re-offered.
- Back-to-back packets: the next header may be offered in the cycle after CHECK.

Optional Feature:
- Macro: ROUTER_LEN_CHECK_EN.
- Defined: the header len field is compared to the accepted payload count at CHECK; a mismatch sets error. len=0 is legal (header followed directly by parity).
- Undefined: len is ignored; no count register; error from parity and invalid destination only.

Test Plan:
- N_DEST=3. Header 0x0D (len 3, dest 1), payload 0x11,0x22,0x33, parity 0x0D.
  -> wr_en=3'b010 for 5 accepted bytes, data_out matches din, error=0, pkt_done pulses 1 cycle after parity.
- Same packet with parity 0x0E.
  -> identical writes, error=1 after CHECK; error cleared when the next valid header is accepted.
- Same packet, fifo_full[1]=1 for 3 cycles while 0x22 is offered.
  -> busy=1 and wr_en=0 those cycles; 0x22 written exactly once after release; error=0.
- Header 0x07 (dest 3, invalid), payload 0xAA, parity 0xAD.
  -> wr_en never asserted, busy=0, error=1, pkt_done pulses.
- rst=1 for one cycle after the second payload byte of the first packet.
  -> error=0, pkt_done=0, IDLE; the next clean packet is processed normally.
- ROUTER_LEN_CHECK_EN defined: header 0x0D with only 2 payload bytes and correct parity.
  -> error=1. With the macro undefined -> error=0.
